// File: rtl/ffd_pipe_pkg.sv
// Shared constants and helpers for the ffd_pipe register pipeline.
package ffd_pipe_pkg;

    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Bits needed to represent an occupancy of 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ffd_stage.sv
// One pipeline slice: a valid/data register pair with its ready term.
module ffd_stage
    import ffd_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             srst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // A stage can take a new beat when empty or when its occupant moves on.
    assign ready = !vld_q || next_ready;
    assign valid = vld_q;
    assign data  = dat_q;

    // Data only loads on a real beat so bubbles leave the register quiet.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ready) begin
            vld_d = prev_valid;
            if (prev_valid) begin
                dat_d = prev_data;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            vld_q <= 1'b0;
            dat_q <= RESET_VAL;
        end else if (srst) begin
            vld_q <= 1'b0;
            dat_q <= RESET_VAL;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/ffd_pipe.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
module ffd_pipe
    import ffd_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                            aclk,
    input  logic                            arst,
    input  logic                            srst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = count_width(DEPTH);

    // Index 0 is the upstream side, index DEPTH the downstream side.
    logic             vld_c [DEPTH+1];
    logic [WIDTH-1:0] dat_c [DEPTH+1];
    logic             rdy_c [DEPTH+1];

    logic          in_xfer, out_xfer;
    logic [CW-1:0] count_q, count_d;

    assign vld_c[0]     = in_valid;
    assign dat_c[0]     = in_data;
    assign rdy_c[DEPTH] = out_ready;

    assign in_ready  = rdy_c[0];
    assign out_valid = vld_c[DEPTH];
    assign out_data  = dat_c[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        ffd_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .aclk       (aclk),
            .arst       (arst),
            .srst       (srst),
            .prev_valid (vld_c[i]),
            .prev_data  (dat_c[i]),
            .next_ready (rdy_c[i+1]),
            .valid      (vld_c[i+1]),
            .data       (dat_c[i+1]),
            .ready      (rdy_c[i])
        );
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_ffd_pipe.sv
// Directed and randomized bench for ffd_pipe against a slot-queue reference model.
module tb_ffd_pipe;

    localparam int unsigned D = 3;
    localparam logic [7:0]  RV = 8'hA5;

    logic       aclk = 1'b0;
    logic       arst, srst;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: occupied slots ordered input->output, plus last emitted payload.
    bit         sv [D];
    logic [7:0] sd [D];
    logic [7:0] last_out;

    ffd_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RV)) dut (
        .aclk      (aclk),
        .arst      (arst),
        .srst      (srst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        int n = 0;
        for (int i = 0; i < int'(D); i++) n += int'(sv[i]);
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(D); i++) begin
            sv[i] = 1'b0;
            sd[i] = RV;
        end
        last_out = RV;
    endfunction

    // Beats drain from the output, then every beat slides into a free slot ahead of it.
    function automatic void model_step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
        if (fl) begin
            model_clear();
            return;
        end
        if (sv[D-1] && ordy) sv[D-1] = 1'b0;
        for (int i = int'(D) - 1; i >= 1; i--) begin
            if (!sv[i] && sv[i-1]) begin
                sv[i]   = 1'b1;
                sd[i]   = sd[i-1];
                sv[i-1] = 1'b0;
                if (i == int'(D) - 1) last_out = sd[i];
            end
        end
        if (!sv[0] && iv) begin
            sv[0] = 1'b1;
            sd[0] = id;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'((occ() < int'(D)) || out_ready));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sv[D-1]));
        chk({tag, ".out_data"},  32'(out_data),  32'(last_out));
        chk({tag, ".count"},     32'(count),     32'(occ()));
    endtask

    // Inputs are already driven; check just before the edge, advance model, cross the edge.
    task automatic tick(input string tag);
        #3;
        check_outputs(tag);
        model_step(in_valid, in_data, out_ready, srst);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        arst = 1'b1; srst = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        model_clear();

        // Reset values
        #100;
        chk("rst.out_valid", 32'(out_valid), 32'(0));
        chk("rst.out_data",  32'(out_data),  32'(RV));
        chk("rst.in_ready",  32'(in_ready),  32'(1));
        chk("rst.count",     32'(count),     32'(0));
        arst = 1'b0;
        @(posedge aclk);
        #1;

        // Streaming 01..08
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            tick("stream");
            if (k == 5) chk("stream.count_mid", 32'(count), 32'(3));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick("drain");

        // Backpressure
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(k);
            tick("bp_fill");
        end
        tick("bp_hold");
        #1;
        chk("bp.in_ready_full", 32'(in_ready), 32'(0));
        chk("bp.out_data_hold", 32'(out_data), 32'(8'h10));
        out_ready = 1'b1;
        tick("bp_release");
        chk("bp.count_kept", 32'(count), 32'(3));
        chk("bp.out_next",   32'(out_data), 32'(8'h11));
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick("bp_drain");

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h21; tick("bub");
        in_valid = 1'b0;                  tick("bub");
        in_valid = 1'b1; in_data = 8'h22; tick("bub");
        in_valid = 1'b0;                  tick("bub");
        tick("bub");
        chk("bub.count",    32'(count),    32'(2));
        chk("bub.in_ready", 32'(in_ready), 32'(1));
        chk("bub.out_data", 32'(out_data), 32'(8'h21));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick("bub_drain");

        // Flush with a pending input beat
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h31 + 8'(k);
            tick("fl_fill");
        end
        srst = 1'b1; in_valid = 1'b1; in_data = 8'h34;
        tick("fl_edge");
        srst = 1'b0; in_valid = 1'b0;
        chk("fl.count",     32'(count),     32'(0));
        chk("fl.out_valid", 32'(out_valid), 32'(0));
        chk("fl.out_data",  32'(out_data),  32'(RV));
        tick("fl_after");

        // Async reset mid-stream
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h41 + 8'(k);
            tick("ar_stream");
        end
        #2;
        arst = 1'b1;
        #1;
        chk("ar.out_valid_now", 32'(out_valid), 32'(0));
        chk("ar.count_now",     32'(count),     32'(0));
        chk("ar.out_data_now",  32'(out_data),  32'(RV));
        model_clear();
        #1;
        arst = 1'b0;
        in_valid = 1'b0;
        @(posedge aclk);
        #1;
        in_valid = 1'b1; in_data = 8'h55;
        tick("ar_push");
        in_valid = 1'b0;
        tick("ar_wait");
        chk("ar.not_yet", 32'(out_valid), 32'(0));
        tick("ar_wait");
        chk("ar.fresh_valid", 32'(out_valid), 32'(1));
        chk("ar.fresh_data",  32'(out_data),  32'(8'h55));
        tick("ar_out");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            srst      = ($urandom_range(0, 39) == 0);
            tick("rand");
        end
        srst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
